// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles everything that crosses the arbiter boundary: the I-side fetch
// request, the D-side load/store request, the shared RAM port and the status
// flags. Signal names follow the CPU/RAM naming used elsewhere in the core.
//
// Modports
//   slave  : the arbiter's view (requests and RAM responses in, strobes out)
//   master : the environment's view (CPU stages + RAM model), mirror image
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // I-side fetch
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              ihit;
  // D-side load/store
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dhit;
  // Shared RAM port
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ready;
  // Status
  logic              busy;
  logic              grant_d;
  logic              err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    output iload, ihit, dload, dhit, ram_ren, ram_wen, ram_addr, ram_store,
           busy, grant_d, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    input  iload, ihit, dload, dhit, ram_ren, ram_wen, ram_addr, ram_store,
           busy, grant_d, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single RAM port between instruction fetch (I-side) and the
// datapath load/store path (D-side). Each access is sequenced through
// IDLE -> IACC/DACC -> IDLE; RAM strobes come from latched request values so
// they stay stable until ram_ready. Completion is reported the same cycle as
// ram_ready with a one-cycle ihit/dhit pulse, and a starvation counter forces
// an I grant after STARVE_MAX consecutive D grants with a fetch waiting.
//
// Ports
//   CLK   : clock, all state updates on the rising edge
//   nRST  : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (requests, RAM port, busy/grant_d/err)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  CLK,
  input  logic                  nRST,
  mem_port_arbiter_if.slave     bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IACC = 2'd1;
  localparam logic [1:0] ST_DACC = 2'd2;

  // Wait counter saturates one past the timeout value so the error compare
  // matches exactly once per access no matter how long the RAM stalls.
  localparam int              WAIT_W     = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(TIMEOUT);
  localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [3:0]        r_starve_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_store;
  logic              r_op_write;
  logic              r_grant_d;
  logic [DATA_W-1:0] r_iload;
  logic [DATA_W-1:0] r_dload;

  logic w_idle;
  logic w_in_iacc;
  logic w_in_dacc;
  logic w_d_pend;
  logic w_force_i;
  logic w_grant_d;
  logic w_grant_i;
  logic w_ihit;
  logic w_dhit;
  logic w_dual_err;
  logic w_timeout_err;

  // Arbitration and completion decode for the current cycle.
  always_comb begin
    w_idle        = (r_state == ST_IDLE);
    w_in_iacc     = (r_state == ST_IACC);
    w_in_dacc     = (r_state == ST_DACC);
    w_d_pend      = bus.dREN | bus.dWEN;
    // Fetch has waited through STARVE_MAX back-to-back D grants: it goes next.
    w_force_i     = (r_starve_cnt == STARVE_LIM) & bus.iREN;
    w_grant_d     = w_idle & w_d_pend & ~w_force_i;
    w_grant_i     = w_idle & ~w_grant_d & bus.iREN;
    // ram_ready is only meaningful while an access is outstanding.
    w_ihit        = w_in_iacc & bus.ram_ready;
    w_dhit        = w_in_dacc & bus.ram_ready;
    w_dual_err    = w_grant_d & bus.dREN & bus.dWEN;
    w_timeout_err = ~w_idle & ~bus.ram_ready & (r_wait_cnt == WAIT_LAST);
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_DACC;
        end else if (w_grant_i) begin
          w_state_nxt = ST_IACC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IACC, ST_DACC: begin
        // Always return through IDLE so requesters can drop or advance.
        if (bus.ram_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Starvation counter: counts D grants taken while a fetch was waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_d) begin
      if (bus.iREN) begin
        if (r_starve_cnt != STARVE_LIM) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end else begin
          r_starve_cnt <= r_starve_cnt;
        end
      end else begin
        r_starve_cnt <= 4'd0;
      end
    end else if (w_grant_i) begin
      r_starve_cnt <= 4'd0;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  // Access wait counter; zero in IDLE so each access starts counting at 0.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wait_cnt <= '0;
    end else if (w_idle || bus.ram_ready) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WAIT_SAT) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  // Request latches and owner flag, captured in the grant cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr     <= '0;
      r_store    <= '0;
      r_op_write <= 1'b0;
      r_grant_d  <= 1'b0;
    end else if (w_grant_d) begin
      r_addr     <= bus.daddr;
      r_store    <= bus.dstore;
      r_op_write <= bus.dWEN;   // dREN&dWEN together is a write
      r_grant_d  <= 1'b1;
    end else if (w_grant_i) begin
      r_addr     <= bus.iaddr;
      r_store    <= r_store;
      r_op_write <= 1'b0;
      r_grant_d  <= 1'b0;
    end else begin
      r_addr     <= r_addr;
      r_store    <= r_store;
      r_op_write <= r_op_write;
      r_grant_d  <= r_grant_d;
    end
  end

  // Hold the last returned word for each side between completions.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_iload <= '0;
      r_dload <= '0;
    end else begin
      if (w_ihit) begin
        r_iload <= bus.ram_load;
      end else begin
        r_iload <= r_iload;
      end
      if (w_dhit) begin
        r_dload <= bus.ram_load;
      end else begin
        r_dload <= r_dload;
      end
    end
  end

  // RAM port drive, sourced only from the latches.
  always_comb begin
    bus.ram_ren   = 1'b0;
    bus.ram_wen   = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_store = '0;
    case (r_state)
      ST_IACC: begin
        bus.ram_ren  = 1'b1;
        bus.ram_addr = r_addr;
      end
      ST_DACC: begin
        bus.ram_ren   = ~r_op_write;
        bus.ram_wen   = r_op_write;
        bus.ram_addr  = r_addr;
        bus.ram_store = r_store;
      end
      default: begin
        bus.ram_ren   = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_store = '0;
      end
    endcase
  end

  // Requester-facing results: data passes through on the hit cycle.
  assign bus.ihit    = w_ihit;
  assign bus.dhit    = w_dhit;
  assign bus.iload   = w_ihit ? bus.ram_load : r_iload;
  assign bus.dload   = w_dhit ? bus.ram_load : r_dload;
  assign bus.busy    = ~w_idle;
  assign bus.grant_d = r_grant_d;
  assign bus.err     = w_dual_err | w_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a per-cycle vector table for the basic
// fetch/store/load/dual-request flows, then hand-written sequences for
// starvation ordering, RAM timeout and reset in the middle of a store.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(64)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] rload;
    logic        rrdy;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic        e_ihit;
    logic        e_dhit;
    logic [31:0] e_iload;
    logic [31:0] e_dload;
    logic        e_busy;
    logic        e_gd;
    logic        e_err;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iren, input logic [31:0] iaddr, input logic dren,
                       input logic dwen, input logic [31:0] daddr, input logic [31:0] dstore,
                       input logic [31:0] rload, input logic rrdy);
    bus_if.iREN      = iren;
    bus_if.iaddr     = iaddr;
    bus_if.dREN      = dren;
    bus_if.dWEN      = dwen;
    bus_if.daddr     = daddr;
    bus_if.dstore    = dstore;
    bus_if.ram_load  = rload;
    bus_if.ram_ready = rrdy;
  endtask

  // Safety net against a hung DUT handshake.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string     seq;
    string     exp_seq;
    int        cyc;
    int        err_cnt;
    int        err_at;
    total = 0;
    bad   = 0;

    //            iren  iaddr        dren  dwen  daddr        dstore       rload         rrdy | ren  wen  addr         store        ihit dhit iload         dload         busy gd   err
    vecs[0]  = '{1'b1, 32'h40,      1'b0, 1'b0, 32'h0,       32'h0,       32'h0,        1'b0,  1'b0, 1'b0, 32'h0,     32'h0,      1'b0,1'b0, 32'h0,        32'h0,        1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1, 32'h40,      1'b0, 1'b0, 32'h0,       32'h0,       32'h0,        1'b0,  1'b1, 1'b0, 32'h40,    32'h0,      1'b0,1'b0, 32'h0,        32'h0,        1'b1,1'b0,1'b0};
    vecs[2]  = '{1'b1, 32'h40,      1'b0, 1'b0, 32'h0,       32'h0,       32'hDEADBEEF, 1'b1,  1'b1, 1'b0, 32'h40,    32'h0,      1'b1,1'b0, 32'hDEADBEEF, 32'h0,        1'b1,1'b0,1'b0};
    vecs[3]  = '{1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,       32'h0,        1'b0,  1'b0, 1'b0, 32'h0,     32'h0,      1'b0,1'b0, 32'hDEADBEEF, 32'h0,        1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,       32'h11111111, 1'b1,  1'b0, 1'b0, 32'h0,     32'h0,      1'b0,1'b0, 32'hDEADBEEF, 32'h0,        1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h200,     32'h1234,    32'h0,        1'b0,  1'b0, 1'b0, 32'h0,     32'h0,      1'b0,1'b0, 32'hDEADBEEF, 32'h0,        1'b0,1'b0,1'b0};
    vecs[6]  = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h300,     32'h9999,    32'h0,        1'b0,  1'b0, 1'b1, 32'h200,   32'h1234,   1'b0,1'b0, 32'hDEADBEEF, 32'h0,        1'b1,1'b1,1'b0};
    vecs[7]  = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h300,     32'h9999,    32'hA5A5A5A5, 1'b1,  1'b0, 1'b1, 32'h200,   32'h1234,   1'b0,1'b1, 32'hDEADBEEF, 32'hA5A5A5A5, 1'b1,1'b1,1'b0};
    vecs[8]  = '{1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,       32'h0,        1'b0,  1'b0, 1'b0, 32'h0,     32'h0,      1'b0,1'b0, 32'hDEADBEEF, 32'hA5A5A5A5, 1'b0,1'b1,1'b0};
    vecs[9]  = '{1'b0, 32'h0,       1'b1, 1'b0, 32'h80,      32'h0,       32'h0,        1'b0,  1'b0, 1'b0, 32'h0,     32'h0,      1'b0,1'b0, 32'hDEADBEEF, 32'hA5A5A5A5, 1'b0,1'b1,1'b0};
    vecs[10] = '{1'b0, 32'h0,       1'b1, 1'b0, 32'h80,      32'h0,       32'hCAFEF00D, 1'b1,  1'b1, 1'b0, 32'h80,    32'h0,      1'b0,1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1,1'b1,1'b0};
    vecs[11] = '{1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,       32'h0,        1'b0,  1'b0, 1'b0, 32'h0,     32'h0,      1'b0,1'b0, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0,1'b1,1'b0};
    vecs[12] = '{1'b0, 32'h0,       1'b1, 1'b1, 32'h44,      32'h77,      32'h0,        1'b0,  1'b0, 1'b0, 32'h0,     32'h0,      1'b0,1'b0, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0,1'b1,1'b1};
    vecs[13] = '{1'b0, 32'h0,       1'b1, 1'b1, 32'h44,      32'h77,      32'h0,        1'b1,  1'b0, 1'b1, 32'h44,    32'h77,     1'b0,1'b1, 32'hDEADBEEF, 32'h0,        1'b1,1'b1,1'b0};
    vecs[14] = '{1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,       32'h0,        1'b0,  1'b0, 1'b0, 32'h0,     32'h0,      1'b0,1'b0, 32'hDEADBEEF, 32'h0,        1'b0,1'b1,1'b0};

    // Power-on reset.
    nRST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst.busy",    32'(bus_if.busy),    32'h0);
    chk("rst.ram_ren", 32'(bus_if.ram_ren), 32'h0);
    chk("rst.grant_d", 32'(bus_if.grant_d), 32'h0);
    chk("rst.iload",   bus_if.iload,        32'h0);
    chk("rst.dload",   bus_if.dload,        32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Vector table: one record per clock cycle.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].iren, vecs[i].iaddr, vecs[i].dren, vecs[i].dwen,
            vecs[i].daddr, vecs[i].dstore, vecs[i].rload, vecs[i].rrdy);
      @(negedge CLK);
      chk($sformatf("v%0d.ram_ren",   i), 32'(bus_if.ram_ren), 32'(vecs[i].e_ren));
      chk($sformatf("v%0d.ram_wen",   i), 32'(bus_if.ram_wen), 32'(vecs[i].e_wen));
      chk($sformatf("v%0d.ram_addr",  i), bus_if.ram_addr,     vecs[i].e_addr);
      chk($sformatf("v%0d.ram_store", i), bus_if.ram_store,    vecs[i].e_store);
      chk($sformatf("v%0d.ihit",      i), 32'(bus_if.ihit),    32'(vecs[i].e_ihit));
      chk($sformatf("v%0d.dhit",      i), 32'(bus_if.dhit),    32'(vecs[i].e_dhit));
      chk($sformatf("v%0d.iload",     i), bus_if.iload,        vecs[i].e_iload);
      chk($sformatf("v%0d.dload",     i), bus_if.dload,        vecs[i].e_dload);
      chk($sformatf("v%0d.busy",      i), 32'(bus_if.busy),    32'(vecs[i].e_busy));
      chk($sformatf("v%0d.grant_d",   i), 32'(bus_if.grant_d), 32'(vecs[i].e_gd));
      chk($sformatf("v%0d.err",       i), 32'(bus_if.err),     32'(vecs[i].e_err));
      @(posedge CLK); #1;
    end

    // Starvation: both sides request continuously, RAM answers in one cycle.
    exp_seq = "DDDDIDDDDI";
    seq = "";
    drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1);
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (bus_if.ihit && bus_if.dhit) begin
        chk("starve.both_hits", 32'h1, 32'h0);
      end
      if (bus_if.ihit) seq = {seq, "I"};
      if (bus_if.dhit) seq = {seq, "D"};
      if (seq.len() == 10) break;
      @(posedge CLK); #1;
    end
    chk("starve.count", 32'(seq.len()), 32'd10);
    total++;
    if (seq != exp_seq) begin
      bad++;
      $display("FAIL starve.order: got %s want %s", seq, exp_seq);
    end
    @(posedge CLK); #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    chk("starve.grant_d_after_i", 32'(bus_if.grant_d), 32'h0);
    chk("starve.idle_busy",       32'(bus_if.busy),    32'h0);

    // Timeout: RAM stalls 70 cycles, err must pulse only on the 64th.
    @(posedge CLK); #1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    chk("tmo.grant_err", 32'(bus_if.err), 32'h0);
    @(posedge CLK); #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    err_cnt = 0;
    err_at  = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge CLK);
      if (bus_if.err) begin
        err_cnt++;
        if (err_at == 0) err_at = k;
      end
      if (k == 70) chk("tmo.addr_held", bus_if.ram_addr, 32'h300);
      @(posedge CLK); #1;
    end
    chk("tmo.err_count", 32'(err_cnt), 32'd1);
    chk("tmo.err_cycle", 32'(err_at),  32'd64);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BADF00D, 1'b1);
    @(negedge CLK);
    chk("tmo.dhit",  32'(bus_if.dhit), 32'h1);
    chk("tmo.dload", bus_if.dload,     32'h0BADF00D);
    chk("tmo.err_at_done", 32'(bus_if.err), 32'h0);
    @(posedge CLK); #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    chk("tmo.idle_busy", 32'(bus_if.busy), 32'h0);

    // Reset in the middle of a store.
    @(posedge CLK); #1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h5, 32'h0, 1'b0);
    @(posedge CLK); #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    chk("rmid.ram_wen_before", 32'(bus_if.ram_wen), 32'h1);
    chk("rmid.ram_addr_before", bus_if.ram_addr,    32'h100);
    #1;
    bus_if.ram_ready = 1'b1;
    bus_if.ram_load  = 32'h77777777;
    nRST = 1'b0;
    #1;
    chk("rmid.ram_wen",  32'(bus_if.ram_wen), 32'h0);
    chk("rmid.dhit",     32'(bus_if.dhit),    32'h0);
    chk("rmid.busy",     32'(bus_if.busy),    32'h0);
    chk("rmid.grant_d",  32'(bus_if.grant_d), 32'h0);
    chk("rmid.dload",    bus_if.dload,        32'h0);
    chk("rmid.err",      32'(bus_if.err),     32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    bus_if.ram_ready = 1'b0;
    @(negedge CLK);
    chk("rmid.post_busy",    32'(bus_if.busy),    32'h0);
    chk("rmid.post_ram_wen", 32'(bus_if.ram_wen), 32'h0);
    chk("rmid.post_dhit",    32'(bus_if.dhit),    32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single RAM port between instruction fetch (I-side) and the datapath load/store path (D-side) in the pipelined CPU.
- Sequences each access through a small FSM and holds RAM signals stable until the RAM completes.
- Returns single-cycle ihit/dhit pulses. The hazard unit uses these to stall or release fetch and memory stages.
- Guarantees forward progress for fetch under back-to-back data traffic.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, max consecutive D grants while iREN pending before an I grant is forced (range 1..15)
TIMEOUT, 64, cycles waiting on ram_ready before err pulse

Ports:
CLK  in  1  clock, all state rises on posedge
nRST  in  1  reset, asynchronous, active-low
iREN  in  1  fetch request
iaddr  in  ADDR_W  fetch address
iload  out  DATA_W  fetched word, valid when ihit
ihit  out  1  fetch complete, 1-cycle pulse
dREN  in  1  load request
dWEN  in  1  store request
daddr  in  ADDR_W  data address
dstore  in  DATA_W  store data
dload  out  DATA_W  loaded word, valid when dhit
dhit  out  1  data access complete, 1-cycle pulse
ram_ren  out  1  RAM read strobe
ram_wen  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address
ram_store  out  DATA_W  RAM write data
ram_load  in  DATA_W  RAM read data
ram_ready  in  1  RAM access done this cycle
busy  out  1  FSM not in IDLE
grant_d  out  1  1 = current/last owner is D-side
err  out  1  1-cycle pulse: timeout or dREN&dWEN together

Behaviour:
- Reset (async, nRST=0): state=IDLE; starve_cnt=0; wait_cnt=0; address/data latches=0.
  - Outputs during reset: ram_ren=ram_wen=0, ihit=dhit=0, busy=0, grant_d=0, err=0, iload=dload=0.
  - Effect is immediate, including mid-access; no completion is reported for an aborted access.
- States: IDLE, IACC, DACC.
- IDLE arbitration, evaluated each cycle:
  - D pending (dREN|dWEN) and not (starve_cnt==STARVE_MAX and iREN): go to DACC. Latch daddr, dstore, and op (write if dWEN).
  - Else if iREN: go to IACC and latch iaddr.
  - Else stay in IDLE.
- Starvation counter:
  - On a D grant, starve_cnt increments (saturating) if iREN=1 that cycle, else clears to 0.
  - On an I grant, starve_cnt clears to 0.
- dREN&dWEN together: treated as a write; err pulses in the grant cycle.
- IACC: ram_ren=1, ram_addr=latched iaddr, ram_wen=0.
- DACC: ram_addr=latched daddr; ram_ren=~op_write; ram_wen=op_write; ram_store=latched dstore.
- Strobes and address are driven from latches only, so requester input changes during an access are ignored.
- Completion:
  - In IACC/DACC with ram_ready=1, ihit or dhit is asserted combinationally in that same cycle.
  - iload/dload = ram_load in that cycle; registered copies hold the value afterwards until the next completion.
  - Next state is IDLE.
  - A mandatory single IDLE cycle follows every access so the requester can drop or advance its request. Minimum access period = RAM latency + 1.
- ihit and dhit are never both 1. Neither is asserted in IDLE.
- Timeout:
  - wait_cnt counts cycles in IACC/DACC and clears on entering IDLE.
  - When it reaches TIMEOUT-1 without ram_ready, err pulses once and the FSM keeps waiting; there is no abort.
- busy = (state != IDLE).
- grant_d updates at each grant and holds through IDLE.
- ram_ready asserted while in IDLE is ignored.

Test Plan:
- Reset mid-DACC store (ram_wen=1, addr 0x100), nRST=0 -> ram_wen=0 in the same cycle, no dhit; after release, state IDLE and busy=0.
- iREN=1 only, iaddr=0x40, RAM ready after 2 cycles with ram_load=0xDEADBEEF -> ram_ren=1, ram_addr=0x40 for 2 cycles; ihit pulses 1 cycle with iload=0xDEADBEEF; 1 idle cycle follows.
- iREN and dREN both held high continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I.
- dWEN=1, daddr=0x200, dstore=0x1234, daddr changed to 0x300 mid-access -> ram_addr stays 0x200, ram_store=0x1234, dhit on ram_ready.
- dREN=dWEN=1 simultaneously -> write performed, err pulses in the grant cycle.
- ram_ready held low for TIMEOUT=64 cycles -> err pulses once at cycle 64 in DACC; the later ram_ready still completes with dhit.
